pipeline_stage_elastic: RTL and testbench
=========================================

# pipeline_stage_elastic

Parametrised pipeline stage register with valid/ready handshake, optional skid buffer, stall input and flush-to-bubble. It replaces the fixed-field stage registers between pipeline stages (fetch/decode/execute/memory/writeback) with one reusable block. Data and control payloads are carried as flat buses, and flush inserts a configurable control bubble. Back-pressure is supported without losing an in-flight instruction.

## Interface
Parameters:
- DATA_W, 128, width of the datapath payload (operands, PC, immediates, register indices).
- CTRL_W, 16, width of the control payload (RegWrite, ALUctrl, branch, jump, ...).
- CTRL_BUBBLE, {CTRL_W{1'b0}}, control pattern presented for a bubble (must encode "no write, no branch, no jump").
- SKID, 1, 1 = two-entry elastic stage with registered in_ready; 0 = single entry with combinational in_ready.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  upstream hold; forces in_ready low, stored entries unaffected.
- flush  in  1  discard all stored entries and the current input beat.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  out_data/out_ctrl hold a live beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DATA_W  datapath payload to next stage.
- out_ctrl  out  CTRL_W  control payload; equals CTRL_BUBBLE whenever out_valid = 0.
- occ  out  2  number of stored beats (0..2; max 1 when SKID = 0).

## Operation
- Storage: main entry (drives outputs) and, if SKID = 1, a skid entry. Each entry has a valid bit.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- SKID = 1: in_ready = !skid_valid && !stall. This depends only on registered state and stall.
- SKID = 0: in_ready = (!main_valid || out_ready) && !stall.
- Update priority, highest first: reset, then flush, then normal.
- Normal update, SKID = 1:
  - Main empty: an accepted beat loads main.
  - Main full, output transfer: main loads skid if skid is valid, else the accepted beat, else main goes empty.
  - Main full, no output transfer: an accepted beat loads skid.
- Normal update, SKID = 0: an accepted beat loads main. Otherwise main goes empty on an output transfer.
- States (SKID = 1): EMPTY (occ 0), ONE (occ 1), FULL (occ 2).
  - EMPTY→ONE on accept.
  - ONE→FULL on accept without pop.
  - ONE→EMPTY on pop without accept.
  - ONE stays ONE on accept+pop.
  - FULL→ONE on pop. No accept is possible in FULL.
- Ordering is strictly FIFO. No beat is duplicated or dropped except by flush.
- Flush:
  - Clears all valid bits. The input beat presented in the same cycle is dropped.
  - out_ctrl becomes CTRL_BUBBLE and out_data becomes 0 on the next edge.
  - Downstream is not required to be ready; flush overrides out_ready = 0.
- Stall with out_ready = 1 still drains stored beats.
- Stall and flush together: flush wins.
- out_ctrl is forced to CTRL_BUBBLE whenever main is empty. out_data holds its last value when empty, except it is zeroed after reset or flush.

## Timing
- Reset (rst_n = 0 at an edge):
  - out_valid = 0, occ = 0, out_data = 0, out_ctrl = CTRL_BUBBLE.
  - in_ready = !stall.
- Reset asserted mid-operation discards all entries at that edge, regardless of flush, stall or handshakes.
- Latency: an accepted beat appears on out_* the cycle after acceptance (1 cycle) when main was empty or was popped.
- Throughput: 1 beat/cycle sustained while out_ready = 1, for both SKID values.
- SKID = 1: after out_ready deasserts, one further beat is absorbed. in_ready drops the cycle after skid fills.
- The cycle after flush: out_valid = 0, occ = 0, in_ready = !stall.

## Test plan
- Reset then stream: rst_n low 2 cycles, release, push data 0x1..0x8 with out_ready = 1 → out_data 0x1..0x8 on consecutive cycles, 1-cycle latency, occ ≤ 1.
- Back-pressure (SKID = 1): stream 0xA,0xB,0xC, drop out_ready after 0xA is shown → 0xB captured in skid, occ = 2, in_ready = 0. Raise out_ready → 0xA,0xB,0xC out in order, no loss.
- Flush mid-stream: occ = 2 with in_valid = 1, pulse flush → next cycle out_valid = 0, out_ctrl = CTRL_BUBBLE, out_data = 0, occ = 0. The input beat is not seen.
- Stall: occ = 1, stall = 1, out_ready = 1 → stored beat drains, in_ready = 0 throughout, occ = 0 next cycle.
- Simultaneous flush + stall + reset: rst_n = 0, flush = 1, stall = 1 → reset values. Then rst_n = 1, flush = 1 → occ stays 0.
- SKID = 0 instance: out_ready = 0 with main full → in_ready = 0 combinationally. out_ready = 1 with in_valid → accept and pop in the same cycle, occ stays 1.

Source files
------------

// File: rtl/pipeline_stage_elastic.sv
// Elastic pipeline stage register with valid/ready handshake.
//
// Holds a datapath payload and a control payload between two pipeline stages.
// SKID != 0 gives a two-entry stage (main + skid) whose in_ready_o depends only
// on registered state and stall_i. SKID == 0 gives a single entry with a
// combinational in_ready_o. flush_i drops every stored beat and the input beat
// of the same cycle, and the output shows a control bubble.
//
// Ports:
//   clk_i        clock, all state on the rising edge
//   rst_ni       synchronous active-low reset
//   stall_i      upstream hold: forces in_ready_o low, stored beats still drain
//   flush_i      discard stored beats and the current input beat
//   in_valid_i   upstream beat present
//   in_ready_o   stage accepts a beat this cycle
//   in_data_i    upstream datapath payload
//   in_ctrl_i    upstream control payload
//   out_valid_o  out_data_o/out_ctrl_o carry a live beat
//   out_ready_i  downstream accepts the beat this cycle
//   out_data_o   datapath payload to the next stage
//   out_ctrl_o   control payload, CTRL_BUBBLE whenever out_valid_o is low
//   occ_o        number of stored beats (0..2)
module pipeline_stage_elastic #(
  parameter int unsigned        DATA_W      = 128,
  parameter int unsigned        CTRL_W      = 16,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
  parameter int unsigned        SKID        = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occ_o
);

  // Encoding equals the occupancy count so occ_o is the state itself.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   main_data_q, main_data_d;
  logic [CTRL_W-1:0]   main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0]   skid_data_q, skid_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;

  logic main_valid;
  logic skid_valid;
  logic accept;
  logic pop;

  assign main_valid = (state_q != StEmpty);
  assign skid_valid = (state_q == StFull);

  always_comb begin
    if (SKID != 0) begin
      in_ready_o = !skid_valid && !stall_i;
    end else begin
      in_ready_o = (!main_valid || out_ready_i) && !stall_i;
    end
  end

  assign accept = in_valid_i && in_ready_o;
  assign pop    = main_valid && out_ready_i;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;

    if (flush_i) begin
      // Flush wins over any handshake, including a pending pop with out_ready_i low.
      state_d     = StEmpty;
      main_data_d = '0;
      main_ctrl_d = CTRL_BUBBLE;
      skid_data_d = '0;
      skid_ctrl_d = CTRL_BUBBLE;
    end else if (SKID != 0) begin
      unique case (state_q)
        StEmpty: begin
          if (accept) begin
            state_d     = StOne;
            main_data_d = in_data_i;
            main_ctrl_d = in_ctrl_i;
          end
        end
        StOne: begin
          if (pop) begin
            if (accept) begin
              main_data_d = in_data_i;
              main_ctrl_d = in_ctrl_i;
            end else begin
              // Payload is kept so out_data_o holds its last value while empty.
              state_d = StEmpty;
            end
          end else if (accept) begin
            state_d     = StFull;
            skid_data_d = in_data_i;
            skid_ctrl_d = in_ctrl_i;
          end
        end
        StFull: begin
          // in_ready_o is low here, so only the skid entry can refill main.
          if (pop) begin
            state_d     = StOne;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
          end
        end
        default: begin
          state_d = StEmpty;
        end
      endcase
    end else begin
      if (accept) begin
        state_d     = StOne;
        main_data_d = in_data_i;
        main_ctrl_d = in_ctrl_i;
      end else if (pop) begin
        state_d = StEmpty;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StEmpty;
      main_data_q <= '0;
      main_ctrl_q <= CTRL_BUBBLE;
      skid_data_q <= '0;
      skid_ctrl_q <= CTRL_BUBBLE;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_valid_o = main_valid;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_valid ? main_ctrl_q : CTRL_BUBBLE;
  assign occ_o       = state_q;

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// Bench for pipeline_stage_elastic: one SKID=1 and one SKID=0 instance share the
// same stimulus; each table vector names which instance it checks.
module tb_pipeline_stage_elastic;

  localparam logic [15:0] Bub1 = 16'h00F0;
  localparam logic [15:0] Bub0 = 16'h0000;

  logic         clk = 1'b0;
  logic         rst_n, stall, flush, in_valid, out_ready;
  logic [127:0] in_data;
  logic [15:0]  in_ctrl;

  logic         ir1, ov1, ir0, ov0;
  logic [127:0] od1, od0;
  logic [15:0]  oc1, oc0;
  logic [1:0]   occ1, occ0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipeline_stage_elastic #(
    .DATA_W     (128),
    .CTRL_W     (16),
    .CTRL_BUBBLE(Bub1),
    .SKID       (1)
  ) u_dut1 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stall_i    (stall),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (ir1),
    .in_data_i  (in_data),
    .in_ctrl_i  (in_ctrl),
    .out_valid_o(ov1),
    .out_ready_i(out_ready),
    .out_data_o (od1),
    .out_ctrl_o (oc1),
    .occ_o      (occ1)
  );

  pipeline_stage_elastic #(
    .DATA_W     (128),
    .CTRL_W     (16),
    .CTRL_BUBBLE(Bub0),
    .SKID       (0)
  ) u_dut0 (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .stall_i    (stall),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (ir0),
    .in_data_i  (in_data),
    .in_ctrl_i  (in_ctrl),
    .out_valid_o(ov0),
    .out_ready_i(out_ready),
    .out_data_o (od0),
    .out_ctrl_o (oc0),
    .occ_o      (occ0)
  );

  // ir is checked before the edge with the vector's inputs applied;
  // ov/od/oc/occ are checked just after the edge.
  typedef struct {
    logic        skid;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        iv;
    logic [7:0]  id;
    logic        ordy;
    logic        ir;
    logic        ov;
    logic [7:0]  od;
    logic [15:0] oc;
    logic [1:0]  occ;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic skid, logic rn, logic st, logic fl, logic iv,
                              logic [7:0] id, logic ordy, logic ir, logic ov,
                              logic [7:0] od, logic [15:0] oc, logic [1:0] occ);
    vec_t r;
    r.skid = skid; r.rst_n = rn; r.stall = st; r.flush = fl; r.iv = iv; r.id = id;
    r.ordy = ordy; r.ir = ir; r.ov = ov; r.od = od; r.oc = oc; r.occ = occ;
    return r;
  endfunction

  task automatic check(string name, int idx, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(vec_t t, int idx);
    rst_n     = t.rst_n;
    stall     = t.stall;
    flush     = t.flush;
    in_valid  = t.iv;
    in_data   = 128'(t.id);
    in_ctrl   = {8'h01, t.id};
    out_ready = t.ordy;
    #4;
    check("in_ready", idx, t.skid ? ir1 : ir0, t.ir);
    @(posedge clk);
    #1;
    check("out_valid", idx, t.skid ? ov1 : ov0, t.ov);
    check("out_data", idx, t.skid ? od1 : od0, 128'(t.od));
    check("out_ctrl", idx, t.skid ? oc1 : oc0, t.oc);
    check("occ", idx, t.skid ? occ1 : occ0, t.occ);
  endtask

  logic [127:0] exp_q[$];
  int sent, recv, cyc;

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; in_ctrl = '0;
    @(posedge clk);
    #1;

    //          sk rn st fl iv id     ordy ir ov od     oc         occ
    // SKID=1: reset, stream 1..8
    tbl.push_back(mk(1, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, Bub1,      0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, Bub1,      0));
    for (int n = 1; n <= 8; n++) begin
      tbl.push_back(mk(1, 1, 0, 0, 1, 8'(n), 1, 1, 1, 8'(n), 16'h0100 + 16'(n), 1));
    end
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h08, Bub1,      0));
    // back-pressure: B into skid, in_ready drops, then A,B,C in order
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h0A, 1, 1, 1, 8'h0A, 16'h010A, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h0B, 0, 1, 1, 8'h0A, 16'h010A, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h0C, 0, 0, 1, 8'h0A, 16'h010A, 2));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h0C, 1, 0, 1, 8'h0B, 16'h010B, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h0C, 1, 1, 1, 8'h0C, 16'h010C, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h0C, Bub1,      0));
    // flush with occ=2, out_ready low, input beat present
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h11, 0, 1, 1, 8'h11, 16'h0111, 1));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h12, 0, 1, 1, 8'h11, 16'h0111, 2));
    tbl.push_back(mk(1, 1, 0, 1, 1, 8'h13, 0, 0, 0, 8'h00, Bub1,      0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00, Bub1,      0));
    // stall drains the stored beat, nothing accepted
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h21, 0, 1, 1, 8'h21, 16'h0121, 1));
    tbl.push_back(mk(1, 1, 1, 0, 1, 8'h22, 1, 0, 0, 8'h21, Bub1,      0));
    tbl.push_back(mk(1, 1, 1, 0, 1, 8'h22, 1, 0, 0, 8'h21, Bub1,      0));
    // reset + flush + stall together, then flush alone
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h31, 0, 1, 1, 8'h31, 16'h0131, 1));
    tbl.push_back(mk(1, 0, 1, 1, 1, 8'h32, 1, 0, 0, 8'h00, Bub1,      0));
    tbl.push_back(mk(1, 1, 0, 1, 1, 8'h33, 1, 1, 0, 8'h00, Bub1,      0));
    tbl.push_back(mk(1, 1, 0, 0, 1, 8'h34, 0, 1, 1, 8'h34, 16'h0134, 1));
    // SKID=0 instance
    tbl.push_back(mk(0, 0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h00, Bub0,      0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 8'h00, 0, 1, 0, 8'h00, Bub0,      0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h41, 0, 1, 1, 8'h41, 16'h0141, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h42, 0, 0, 1, 8'h41, 16'h0141, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h42, 1, 1, 1, 8'h42, 16'h0142, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h43, 1, 1, 1, 8'h43, 16'h0143, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8'h00, 1, 1, 0, 8'h43, Bub0,      0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h44, 0, 1, 1, 8'h44, 16'h0144, 1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 8'h45, 0, 0, 0, 8'h00, Bub0,      0));
    tbl.push_back(mk(0, 1, 1, 0, 1, 8'h45, 1, 0, 0, 8'h00, Bub0,      0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h46, 0, 1, 1, 8'h46, 16'h0146, 1));
    tbl.push_back(mk(0, 1, 1, 0, 1, 8'h47, 1, 0, 0, 8'h46, Bub0,      0));

    foreach (tbl[i]) run_vec(tbl[i], i);

    // Random back-pressure on the SKID=1 instance: strict FIFO order, no loss.
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sent = 0; recv = 0; cyc = 0;
    while (recv < 20 && cyc < 400) begin
      in_valid  = (sent < 20);
      in_data   = 128'(200 + sent);
      in_ctrl   = 16'(200 + sent);
      out_ready = 1'($urandom_range(0, 1));
      #4;
      if (ov1 && out_ready) begin
        if (exp_q.size() == 0) begin
          check("fifo_spurious", recv, 128'(ov1), 128'(0));
        end else begin
          check("fifo_data", recv, od1, exp_q[0]);
          check("fifo_ctrl", recv, 128'(oc1), 128'(exp_q[0][15:0]));
          void'(exp_q.pop_front());
        end
        recv++;
      end
      if (in_valid && ir1) begin
        exp_q.push_back(128'(200 + sent));
        sent++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("fifo_count", 0, 128'(recv), 128'(20));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
